// File: rtl/light_phase_scheduler.sv
// Two-way intersection phase sequencer with per-direction BCD countdown displays.
// Define LIGHT_WINK_EN to build the idle-traffic wink (flash) mode and its idle counter.
module light_phase_scheduler #(
    parameter int GREEN_A_SEC = 30,
    parameter int GREEN_B_SEC = 30,
    parameter int ALL_RED_SEC = 3,
    parameter int IDLE_SEC    = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    input  logic       A,
    input  logic       B,
    input  logic       R,
    output logic       A_Light,
    output logic       B_Light,
    output logic [3:0] A_Time_L,
    output logic [3:0] A_Time_H,
    output logic [3:0] B_Time_L,
    output logic [3:0] B_Time_H,
    output logic [2:0] Phase
);
    typedef enum logic [2:0] {
        ALLRED_TO_A = 3'd0,
        GREEN_A     = 3'd1,
        ALLRED_TO_B = 3'd2,
        GREEN_B     = 3'd3,
        WINK        = 3'd4,
        MANUAL      = 3'd5
    } phase_t;

    localparam logic [6:0] GA_CNT = 7'(GREEN_A_SEC);
    localparam logic [6:0] GB_CNT = 7'(GREEN_B_SEC);
    localparam logic [6:0] AR_CNT = 7'(ALL_RED_SEC);
    localparam logic [7:0] GB_8   = 8'(GREEN_B_SEC);
    localparam logic [7:0] GA_8   = 8'(GREEN_A_SEC);
    localparam logic [7:0] AR_8   = 8'(ALL_RED_SEC);

    phase_t     state_reg;
    logic [6:0] count_reg;
    logic       blink_reg;
    logic       last_tick;
    logic       state_ok;
    logic       go_wink;
    logic       manual_req;
    logic       manual_exit;

    assign last_tick   = (count_reg <= 7'd1);
    assign manual_req  = (A | B) & ~R;
    assign manual_exit = R | ~(A | B);

`ifdef LIGHT_WINK_EN
    localparam logic [6:0] IDLE_CNT = 7'(IDLE_SEC);
    logic [5:0] idle_reg;
    logic [5:0] idle_next;

    assign state_ok  = (state_reg <= MANUAL);
    assign idle_next = (A_Traffic | B_Traffic) ? 6'd0 :
                       (idle_reg == 6'd63)     ? 6'd63 : idle_reg + 6'd1;
    assign go_wink   = ({1'b0, idle_reg} >= IDLE_CNT);

    // Outside the timed phases idle is held at zero, so every exit starts fresh.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            idle_reg <= 6'd0;
        end else if (state_reg[2]) begin
            idle_reg <= 6'd0;
        end else if (Tick && !manual_req) begin
            idle_reg <= idle_next;
        end
    end
`else
    assign state_ok = (state_reg <= MANUAL) && (state_reg != WINK);
    assign go_wink  = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= ALLRED_TO_A;
            count_reg <= AR_CNT;
            blink_reg <= 1'b0;
        end else if (!state_ok) begin
            state_reg <= ALLRED_TO_A;
            count_reg <= AR_CNT;
        end else if (state_reg == MANUAL) begin
            if (manual_exit) begin
                state_reg <= ALLRED_TO_A;
                count_reg <= AR_CNT;
            end
        end else if (manual_req) begin
            state_reg <= MANUAL;
        end else if (Tick) begin
            case (state_reg)
                ALLRED_TO_A: begin
                    if (last_tick) begin
                        state_reg <= GREEN_A;
                        count_reg <= GA_CNT;
                    end else begin
                        count_reg <= count_reg - 7'd1;
                    end
                end
                ALLRED_TO_B: begin
                    if (last_tick) begin
                        state_reg <= GREEN_B;
                        count_reg <= GB_CNT;
                    end else begin
                        count_reg <= count_reg - 7'd1;
                    end
                end
                GREEN_A: begin
                    if (!last_tick) begin
                        count_reg <= count_reg - 7'd1;
                    end else if (go_wink) begin
                        state_reg <= WINK;
                        blink_reg <= 1'b0;
                    end else if (A_Traffic && !B_Traffic) begin
                        count_reg <= GA_CNT;
                    end else begin
                        state_reg <= ALLRED_TO_B;
                        count_reg <= AR_CNT;
                    end
                end
                GREEN_B: begin
                    if (!last_tick) begin
                        count_reg <= count_reg - 7'd1;
                    end else if (go_wink) begin
                        state_reg <= WINK;
                        blink_reg <= 1'b0;
                    end else if (B_Traffic && !A_Traffic) begin
                        count_reg <= GB_CNT;
                    end else begin
                        state_reg <= ALLRED_TO_A;
                        count_reg <= AR_CNT;
                    end
                end
                WINK: begin
                    blink_reg <= ~blink_reg;
                    if (A_Traffic) begin
                        state_reg <= ALLRED_TO_A;
                        count_reg <= AR_CNT;
                    end else if (B_Traffic) begin
                        state_reg <= ALLRED_TO_B;
                        count_reg <= AR_CNT;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0] count_8;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic       blank;

    assign count_8 = {1'b0, count_reg};

    // Each display shows the seconds until that direction's light next changes.
    always_comb begin
        A_Light = 1'b0;
        B_Light = 1'b0;
        a_val   = count_8;
        b_val   = count_8;
        blank   = 1'b0;
        case (state_reg)
            ALLRED_TO_A: b_val = count_8 + GA_8 + AR_8;
            GREEN_A: begin
                A_Light = 1'b1;
                b_val   = count_8 + AR_8;
            end
            ALLRED_TO_B: a_val = count_8 + GB_8 + AR_8;
            GREEN_B: begin
                B_Light = 1'b1;
                a_val   = count_8 + AR_8;
            end
            WINK: begin
                A_Light = blink_reg;
                B_Light = blink_reg;
                blank   = 1'b1;
            end
            MANUAL: begin
                A_Light = A & ~B;
                B_Light = B & ~A;
                blank   = 1'b1;
            end
            default: blank = 1'b1;
        endcase
    end

    logic [1:0][7:0] disp_val;
    logic [1:0][3:0] digit_h;
    logic [1:0][3:0] digit_l;

    assign disp_val = {b_val, a_val};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_bcd
        logic [7:0] sat;
        assign sat          = (disp_val[gi] > 8'd99) ? 8'd99 : disp_val[gi];
        assign digit_h[gi]  = blank ? 4'hF : 4'(sat / 8'd10);
        assign digit_l[gi]  = blank ? 4'hF : 4'(sat % 8'd10);
    end

    assign A_Time_H = digit_h[0];
    assign A_Time_L = digit_l[0];
    assign B_Time_H = digit_h[1];
    assign B_Time_L = digit_l[1];
    assign Phase    = state_reg;

endmodule

// File: doc/light_phase_scheduler.md
Name: light_phase_scheduler

Overview:
Two-way intersection phase sequencer driving the A/B lights and per-direction two-digit BCD countdown displays. It sequences all-red, A-green, all-red and B-green phases from a 1 Hz tick strobe, and extends or skips greens based on the A_Traffic/B_Traffic sensors. It drops into wink (flash) mode when both directions are idle, and hands the lights to the police-override inputs A/B/R when manual control is requested.

Parameters:
GREEN_A_SEC, 30, A green duration in ticks (1..90)
GREEN_B_SEC, 30, B green duration in ticks (1..90)
ALL_RED_SEC, 3, all-red clearance duration in ticks (1..9)
IDLE_SEC, 5, consecutive no-traffic ticks before wink (1..63)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous reset, active-low
Tick  in  1  one-Clk-wide 1 Hz enable strobe
A_Traffic  in  1  vehicle present on A
B_Traffic  in  1  vehicle present on B
A  in  1  manual request: A green
B  in  1  manual request: B green
R  in  1  manual release (1 = return to automatic)
A_Light  out  1  1 = A green, 0 = A red
B_Light  out  1  1 = B green, 0 = B red
A_Time_L  out  4  A countdown, BCD ones digit (4'hF = blank)
A_Time_H  out  4  A countdown, BCD tens digit (4'hF = blank)
B_Time_L  out  4  B countdown, BCD ones digit
B_Time_H  out  4  B countdown, BCD tens digit
Phase  out  3  0 ALLRED_TO_A, 1 GREEN_A, 2 ALLRED_TO_B, 3 GREEN_B, 4 WINK, 5 MANUAL

Behaviour:
- Reset (Rst=0, asynchronous): Phase=ALLRED_TO_A, count=ALL_RED_SEC, idle=0, blink=0, A_Light=B_Light=0. Release is synchronous to the next Clk edge.
- State, count (7-bit binary), idle and blink are registers. All outputs are a combinational decode of those registers, so outputs change in the same cycle the registers update.
- Phase timing: entering a phase loads count with its duration N. A Tick with count>1 decrements count. A Tick with count==1 ends the phase and loads the next phase's duration. Every timed phase therefore lasts exactly N ticks.
- Transitions at phase end:
  - ALLRED_TO_A -> GREEN_A.
  - ALLRED_TO_B -> GREEN_B.
  - GREEN_A, when idle>=IDLE_SEC -> WINK.
  - GREEN_A, else when A_Traffic=1 and B_Traffic=0 -> GREEN_A (reload, extend).
  - GREEN_A, else -> ALLRED_TO_B.
  - GREEN_B: symmetric to GREEN_A, with A and B swapped and -> ALLRED_TO_A.
- Idle counter: on each Tick in a timed phase, idle increments (saturating at 63) if A_Traffic=B_Traffic=0, else clears to 0.
- Lights: A_Light=1 only in GREEN_A; B_Light=1 only in GREEN_B. Both lights are 0 in the all-red phases.
- Countdown values (binary, then converted to BCD, saturating at 99):
  - GREEN_A: A=count, B=count+ALL_RED_SEC.
  - ALLRED_TO_B: B=count, A=count+GREEN_B_SEC+ALL_RED_SEC.
  - GREEN_B and ALLRED_TO_A: mirror images of the two rules above.
  - A value below 10 shows tens digit 0, not blank.
- WINK:
  - Entry clears blink to 0.
  - blink toggles on each Tick; A_Light=B_Light=blink.
  - All time digits are 4'hF.
  - On a Tick with A_Traffic=1 -> ALLRED_TO_A. Else on a Tick with B_Traffic=1 -> ALLRED_TO_B. A wins ties. idle clears on exit.
- MANUAL:
  - Entry: (A|B)&~R sampled at any Clk edge, from any phase, without waiting for Tick. Manual takes priority over Tick in the same cycle.
  - In MANUAL: A_Light=A&~B and B_Light=B&~A (both requested gives both red). All digits are 4'hF.
  - Exit on the edge where R=1 or A=B=0 -> ALLRED_TO_A with count=ALL_RED_SEC and idle=0. A Tick in the exit cycle is ignored.
- A_Light and B_Light are never both 1 in any state. Phase values 6 and 7 are unreachable; if either is ever reached, recover to ALLRED_TO_A on the next edge.

Optional Feature:
LIGHT_WINK_EN: when defined, the WINK state and idle counter are implemented as above. When undefined, there is no WINK state and no idle counter: a green-phase end with no traffic on either side proceeds to the next all-red phase, and Phase never reads 4.

Test Plan:
All scenarios use GREEN_A=5, GREEN_B=4, ALL_RED=2, IDLE=6, with Tick every 4 Clk.
1. Release reset, A_Traffic=B_Traffic=1 -> ALLRED_TO_A for 2 ticks (A_Time 02,01). Then GREEN_A for 5 ticks (A_Time 05..01, B_Time 07..03, A_Light=1). Then ALLRED_TO_B for 2 ticks, then GREEN_B, with B_Light=1 for 4 ticks.
2. A_Traffic=1, B_Traffic=0 at the GREEN_A end tick -> Phase stays 1, A_Time reloads to 05, B_Light stays 0.
3. LIGHT_WINK_EN defined, both sensors 0 for 6+ ticks, then a green ends -> Phase=4, lights toggle 0/1 per tick in unison, digits F. Raise B_Traffic -> next tick Phase=2, B_Time=02.
4. Mid GREEN_B: A=1, B=0, R=0 -> next Clk Phase=5, A_Light=1, B_Light=0, digits FF. Set B=1 -> both lights 0. Set R=1 -> next Clk Phase=0, count=2.
5. Drive Rst=0 between Clk edges during GREEN_A -> A_Light=0 and Phase=0 immediately, with no Clk edge. Release Rst -> the first Tick decrements A_Time from 02 to 01.
6. GREEN_B=90, ALL_RED=9, in ALLRED_TO_B with count=9 -> A_Time_H=9, A_Time_L=9 (saturated); B_Time=09.
